data_memory_lsu: RTL and testbench
==================================

# data_memory_lsu

Parametrised, handshaked data memory for the mini-CPU load/store path, replacing the fixed 64-bit, always-ready data memory. It accepts one load or store request at a time over a valid/ready interface. Access width and signedness are selected with RISC-V funct3 encoding (byte/half/word/double, signed/unsigned loads). A programmable wait-state count models slower memory, and misaligned or out-of-range accesses are flagged instead of silently corrupting data.

## Interface
- XLEN, 64: data/address width; legal values 32 or 64
- DEPTH_WORDS, 128: number of XLEN-bit words; byte capacity DEPTH_WORDS*XLEN/8
- WAIT_CYCLES, 0: extra BUSY cycles per access; range 0..15

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V load/store funct3
- req_addr  in  XLEN  byte address
- req_wdata  in  XLEN  store data, LSBs used for narrow stores
- resp_valid  out  1  one-cycle response strobe
- resp_rdata  out  XLEN  load result, extended to XLEN
- resp_err  out  1  access rejected

## Operation
- Storage: DEPTH_WORDS x XLEN array, little-endian byte lanes. Word index is req_addr / (XLEN/8); lane is the low log2(XLEN/8) address bits.
- funct3 decoding:
  - 000 byte, 001 half, 010 word, 011 double (XLEN=64 only)
  - Loads 000/001/010 sign-extend; 100/101/110 zero-extend (110 requires XLEN=64)
  - 111, and any store with funct3[2]=1, are illegal.
- Error conditions, any of:
  - illegal funct3
  - misalignment: half needs addr[0]=0; word needs addr[1:0]=0; double needs addr[2:0]=0
  - req_addr >= DEPTH_WORDS*XLEN/8
- On error:
  - no array write
  - resp_rdata=0, resp_err=1
- Stores:
  - Write only the addressed bytes; other bytes of the word are untouched.
  - Response has resp_rdata=0, resp_err=0.
- Loads return the addressed bytes, extended per funct3.
- FSM states IDLE, BUSY, RESP:
  - IDLE: req_ready=1. On req_valid, latch write, funct3, addr and wdata; load the wait counter with WAIT_CYCLES; go to BUSY.
  - BUSY: req_ready=0. If counter==0, go to RESP; else decrement.
  - RESP: resp_valid=1 for exactly this cycle, then IDLE. No response back-pressure.
- Commit point: the store write and the load data/err capture happen on the BUSY->RESP edge. resp_rdata and resp_err are registered and held until the next RESP.
- Latched request fields are used throughout, so input changes after acceptance have no effect.

## Timing
- Reset (async assert):
  - state=IDLE, counter=0
  - whole array cleared to 0
  - resp_valid=0, resp_rdata=0, resp_err=0
  - req_ready=0 while rst=1
  - An in-flight store is discarded; no partial write.
- After rst deasserts, req_ready=1 from the first cycle. Requests while rst=1 are ignored.
- Acceptance at edge k:
  - resp_valid is high in the cycle following edge k+WAIT_CYCLES+1.
  - Minimum request spacing is WAIT_CYCLES+3 cycles.
- Load latency = WAIT_CYCLES+2 cycles from request assertion (accepted immediately) to the resp_valid cycle.
- A store followed by a load to the same address returns the new data, since the commit precedes the next acceptance.
- req_ready is combinational from state only (never from req_valid).
- Counter width is 4 bits. WAIT_CYCLES=0 gives exactly one BUSY cycle.

## Test plan
- Store in reset:
  - Stimulus: rst=1, req_valid=1, sd 5 to addr 8, held 2 cycles.
  - Required: req_ready=0, no resp_valid. After reset release, ld addr 8 returns 0 with resp_err=0.
- Fill/readback (defaults):
  - Stimulus: sd n to addr 8n for n=0..127, then ld each.
  - Required: resp_rdata=n and resp_err=0 for every access; resp_valid exactly 2 cycles after each acceptance.
- Byte lanes and extension:
  - Stimulus: sd 0 to addr 16; sb 0x80 to addr 19; sh 0xBEEF to addr 20.
  - Required: ld 16 -> 0x0000BEEF80000000; lb 19 -> 0xFFFFFFFFFFFFFF80; lbu 19 -> 0x80; lh 20 -> 0xFFFFFFFFFFFFBEEF; lwu 16 -> 0x80000000.
- Errors:
  - Stimulus 1: lw addr 2. Required: resp_err=1, resp_rdata=0.
  - Stimulus 2: sd 0xFF to addr 1024. Required: resp_err=1.
  - Stimulus 3: store with funct3=100. Required: resp_err=1.
  - Stimulus 4: sh addr 3. Required: resp_err=1, and a subsequent ld addr 0 is unchanged.
- Wait states and mid-access reset (WAIT_CYCLES=3):
  - Stimulus: ld.
  - Required: resp_valid 5 cycles after acceptance; req_ready low for 5 cycles.
  - Stimulus: sd 0x1234 to addr 0, with rst pulsed during BUSY.
  - Required: resp_valid never asserts; ld addr 0 after reset returns 0.
- XLEN=32, DEPTH_WORDS=64:
  - Stimulus: sw 0xDEADBEEF to addr 4, then lw addr 4; separately, a funct3=011 access.
  - Required: lw addr 4 -> 0xDEADBEEF; funct3=011 -> resp_err=1; addr 256 -> resp_err=1.

Source files
------------

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: handshaked load/store data memory with funct3 sizing, wait states and error flagging
module data_memory_lsu #(
  parameter int XLEN = 64,
  parameter int DEPTH_WORDS = 128,
  parameter int WAIT_CYCLES = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err
);
  localparam int NB = XLEN / 8;
  localparam int LB = $clog2(NB);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH_WORDS * NB);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic a_write;
  logic [2:0] a_f3;
  logic [XLEN-1:0] a_addr, a_wdata;
  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] word, shifted, fm, top, rdata, wmask, wdata_sh;
  logic [LB+2:0] sh;
  logic [AW-1:0] idx;
  logic [1:0] sz;
  logic err, commit;
  assign sz = a_f3[1:0];
  assign idx = a_addr[LB +: AW];
  assign sh = {a_addr[LB-1:0], 3'b000};
  assign word = mem[idx];
  assign shifted = word >> sh;
  assign fm = (XLEN'(1) << (7'd8 << sz)) - XLEN'(1);
  assign top = fm & ~(fm >> 1);
  assign rdata = (shifted & fm) | ((!a_f3[2] && |(shifted & top)) ? ~fm : '0);
  assign wmask = fm << sh;
  assign wdata_sh = (a_wdata & fm) << sh;
  assign err = a_f3 == 3'b111 || (a_write && a_f3[2])
            || (XLEN == 32 && (sz == 2'd3 || a_f3 == 3'b110))
            || |(a_addr[2:0] & ((3'd1 << sz) - 3'd1))
            || a_addr >= LIMIT;
  assign commit = state == BUSY && cnt == 4'd0;
  assign req_ready = state == IDLE && !rst;
  assign resp_valid = state == RESP;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = req_valid ? BUSY : IDLE;
    else if (state == BUSY) state_n = cnt == 4'd0 ? RESP : BUSY;
    else state_n = IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 4'd0;
      a_write <= 1'b0;
      a_f3 <= 3'd0;
      a_addr <= '0;
      a_wdata <= '0;
      resp_rdata <= '0;
      resp_err <= 1'b0;
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && req_valid) begin
        a_write <= req_write;
        a_f3 <= req_funct3;
        a_addr <= req_addr;
        a_wdata <= req_wdata;
        cnt <= 4'(WAIT_CYCLES);
      end else if (state == BUSY && cnt != 4'd0) cnt <= cnt - 4'd1;
      if (commit) begin
        resp_rdata <= (err || a_write) ? '0 : rdata;
        resp_err <= err;
        if (!err && a_write) mem[idx] <= (word & ~wmask) | wdata_sh;
      end
    end
  end
endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: table-driven and scoreboard checks over default, wait-state and 32-bit instances
module tb_data_memory_lsu;
  typedef struct {logic [63:0] d; logic e;} exp_t;
  typedef struct {logic wr; logic [2:0] f3; logic [63:0] addr, wdata, exp; logic err;} vec_t;
  logic clk = 0, rst = 1, req_valid = 0, req_write = 0;
  logic [2:0] req_funct3 = 0;
  logic [63:0] req_addr = 0, req_wdata = 0;
  int sel = 0, asserts = 0, fails = 0;
  logic [2:0] rdy, vld, er, v_in;
  logic [63:0] r0, r1;
  logic [31:0] r2;
  logic cur_ready, cur_valid, cur_err;
  logic [63:0] cur_rdata;
  exp_t q[$];
  vec_t tbl[18];
  always #5 clk = ~clk;
  assign v_in = {sel == 2, sel == 1, sel == 0} & {3{req_valid}};
  assign cur_ready = rdy[sel];
  assign cur_valid = vld[sel];
  assign cur_err = er[sel];
  assign cur_rdata = sel == 0 ? r0 : sel == 1 ? r1 : {32'd0, r2};
  data_memory_lsu dut0 (.clk(clk), .rst(rst), .req_valid(v_in[0]), .req_ready(rdy[0]), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld[0]), .resp_rdata(r0), .resp_err(er[0]));
  data_memory_lsu #(.WAIT_CYCLES(3)) dut1 (.clk(clk), .rst(rst), .req_valid(v_in[1]), .req_ready(rdy[1]), .req_write(req_write),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(vld[1]), .resp_rdata(r1), .resp_err(er[1]));
  data_memory_lsu #(.XLEN(32), .DEPTH_WORDS(64)) dut2 (.clk(clk), .rst(rst), .req_valid(v_in[2]), .req_ready(rdy[2]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr[31:0]), .req_wdata(req_wdata[31:0]),
    .resp_valid(vld[2]), .resp_rdata(r2), .resp_err(er[2]));
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (sel %0d, t=%0t)", name, act, exp, sel, $time);
    end
  endtask
  always @(negedge clk) if (cur_valid) begin
    exp_t x;
    if (q.size() == 0) chk("unexpected_resp", 64'(cur_valid), 64'd0);
    else begin
      x = q.pop_front();
      chk("rdata", cur_rdata, x.d);
      chk("err", 64'(cur_err), 64'(x.e));
    end
  end
  task automatic xact(input logic wr, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] d,
                      input logic [63:0] exp, input logic e);
    int n;
    logic low_ok;
    n = 0;
    @(negedge clk);
    while (!cur_ready && n < 50) begin @(negedge clk); n++; end
    req_valid = 1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = d;
    q.push_back('{exp, e});
    @(posedge clk); #1;
    req_valid = 0; req_write = ~wr; req_funct3 = 3'($urandom); req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    n = 1; low_ok = 1;
    while (!cur_valid && n < 40) begin
      if (cur_ready) low_ok = 0;
      @(posedge clk); #1; n++;
    end
    if (cur_ready) low_ok = 0;
    chk("latency", 64'(n), sel == 1 ? 64'd5 : 64'd2);
    chk("ready_low", 64'(low_ok), 64'd1);
    @(posedge clk); #1;
    chk("ready_back", 64'(cur_ready), 64'd1);
  endtask
  initial begin
    tbl[0]  = '{1, 3'b011, 64'd16, 64'd0, 64'd0, 0};
    tbl[1]  = '{1, 3'b000, 64'd19, 64'h80, 64'd0, 0};
    tbl[2]  = '{1, 3'b001, 64'd20, 64'hBEEF, 64'd0, 0};
    tbl[3]  = '{0, 3'b011, 64'd16, 64'd0, 64'h0000BEEF80000000, 0};
    tbl[4]  = '{0, 3'b000, 64'd19, 64'd0, 64'hFFFFFFFFFFFFFF80, 0};
    tbl[5]  = '{0, 3'b100, 64'd19, 64'd0, 64'h80, 0};
    tbl[6]  = '{0, 3'b001, 64'd20, 64'd0, 64'hFFFFFFFFFFFFBEEF, 0};
    tbl[7]  = '{0, 3'b110, 64'd16, 64'd0, 64'h80000000, 0};
    tbl[8]  = '{0, 3'b010, 64'd16, 64'd0, 64'hFFFFFFFF80000000, 0};
    tbl[9]  = '{1, 3'b011, 64'd0, 64'h1122334455667788, 64'd0, 0};
    tbl[10] = '{0, 3'b010, 64'd2, 64'd0, 64'd0, 1};
    tbl[11] = '{1, 3'b011, 64'd1024, 64'hFF, 64'd0, 1};
    tbl[12] = '{1, 3'b100, 64'd0, 64'hFF, 64'd0, 1};
    tbl[13] = '{1, 3'b001, 64'd3, 64'hAAAA, 64'd0, 1};
    tbl[14] = '{0, 3'b111, 64'd0, 64'd0, 64'd0, 1};
    tbl[15] = '{0, 3'b011, 64'd0, 64'd0, 64'h1122334455667788, 0};
    tbl[16] = '{0, 3'b100, 64'd1023, 64'd0, 64'd0, 0};
    tbl[17] = '{0, 3'b011, 64'd1020, 64'd0, 64'd0, 1};
    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'b011; req_addr = 8; req_wdata = 5;
    repeat (2) begin
      @(posedge clk); #1;
      chk("rst_ready", 64'(cur_ready), 64'd0);
      chk("rst_valid", 64'(cur_valid), 64'd0);
    end
    req_valid = 0;
    @(negedge clk); rst = 0; #1;
    chk("ready_after_rst", 64'(cur_ready), 64'd1);
    chk("rst_rdata", cur_rdata, 64'd0);
    xact(0, 3'b011, 64'd8, 64'd0, 64'd0, 0);
    for (int n = 0; n < 128; n++) xact(1, 3'b011, 64'(8 * n), 64'(n), 64'd0, 0);
    for (int n = 0; n < 128; n++) xact(0, 3'b011, 64'(8 * n), 64'd0, 64'(n), 0);
    foreach (tbl[i]) xact(tbl[i].wr, tbl[i].f3, tbl[i].addr, tbl[i].wdata, tbl[i].exp, tbl[i].err);
    sel = 1;
    xact(1, 3'b011, 64'd8, 64'h55, 64'd0, 0);
    xact(0, 3'b011, 64'd0, 64'd0, 64'd0, 0);
    xact(0, 3'b011, 64'd8, 64'd0, 64'h55, 0);
    @(negedge clk);
    req_valid = 1; req_write = 1; req_funct3 = 3'b011; req_addr = 0; req_wdata = 64'h1234;
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #3 rst = 1;
    #1;
    chk("midrst_rdata", cur_rdata, 64'd0);
    chk("midrst_err", 64'(cur_err), 64'd0);
    chk("midrst_ready", 64'(cur_ready), 64'd0);
    @(negedge clk); rst = 0;
    repeat (10) begin @(posedge clk); #1; chk("no_resp", 64'(cur_valid), 64'd0); end
    xact(0, 3'b011, 64'd0, 64'd0, 64'd0, 0);
    xact(0, 3'b011, 64'd8, 64'd0, 64'd0, 0);
    sel = 2;
    xact(1, 3'b010, 64'd4, 64'hDEADBEEF, 64'd0, 0);
    xact(0, 3'b010, 64'd4, 64'd0, 64'hDEADBEEF, 0);
    xact(0, 3'b000, 64'd5, 64'd0, 64'hFFFFFFBE, 0);
    xact(0, 3'b011, 64'd0, 64'd0, 64'd0, 1);
    xact(1, 3'b011, 64'd0, 64'd1, 64'd0, 1);
    xact(0, 3'b110, 64'd4, 64'd0, 64'd0, 1);
    xact(0, 3'b010, 64'd256, 64'd0, 64'd0, 1);
    xact(0, 3'b100, 64'd255, 64'd0, 64'd0, 0);
    repeat (3) @(posedge clk);
    chk("queue_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule
